// File: rtl/i2c_xact_arbiter_if.sv
// Bundle between the requesters/i2c_wrapper side (master) and the round-robin
// transaction arbiter (slave).
interface i2c_xact_arbiter_if #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 6,
  parameter int NREQ      = 2
);
  localparam int SW = $clog2(DATAWIDTH);

  // requester side
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0]           req_wr;
  logic [NREQ*ADDRWIDTH-1:0] req_addr;
  logic [NREQ*DATAWIDTH-1:0] req_d;
  logic [NREQ*SW-1:0]        req_s;
  logic [NREQ-1:0]           req_msbin;
  logic [NREQ-1:0]           req_lsbin;
  logic [NREQ-1:0]           done;
  logic [DATAWIDTH-1:0]      rdata;
  logic                      timeout_err;
  logic                      busy;

  // wrapper side
  logic [ADDRWIDTH-1:0]      addr;
  logic [DATAWIDTH-1:0]      D;
  logic [SW-1:0]             S;
  logic                      MSBIn;
  logic                      LSBIn;
  logic                      wr_en;
  logic                      rd_en;
  logic [DATAWIDTH-1:0]      dataout;
  logic                      DataValid;

  modport master (
    output req, req_wr, req_addr, req_d, req_s, req_msbin, req_lsbin,
    output dataout, DataValid,
    input  done, rdata, timeout_err, busy,
    input  addr, D, S, MSBIn, LSBIn, wr_en, rd_en
  );

  modport slave (
    input  req, req_wr, req_addr, req_d, req_s, req_msbin, req_lsbin,
    input  dataout, DataValid,
    output done, rdata, timeout_err, busy,
    output addr, D, S, MSBIn, LSBIn, wr_en, rd_en
  );
endinterface

// File: rtl/i2c_xact_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2c_wrapper between NREQ requesters:
// grant, one-cycle wr_en/rd_en pulse, settle or wait for DataValid, then done.
module i2c_xact_arbiter #(
  parameter int DATAWIDTH   = 8,
  parameter int ADDRWIDTH   = 6,
  parameter int NREQ        = 2,
  parameter int WR_WAIT_CYC = 40,
  parameter int RD_TIMEOUT  = 64
) (
  input  logic clk,
  input  logic reset,
  i2c_xact_arbiter_if.slave bus
);
  localparam int SW      = $clog2(DATAWIDTH);
  localparam int IW      = $clog2(NREQ);
  localparam int CNT_MAX = (WR_WAIT_CYC > RD_TIMEOUT) ? WR_WAIT_CYC : RD_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, DONE} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gnt_q, gnt_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic [DATAWIDTH-1:0] rdata_q, rdata_d;
  logic                 terr_q, terr_d;
  logic                 busy_q, busy_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] d_q, d_d;
  logic [SW-1:0]        s_q, s_d;
  logic                 msb_q, msb_d;
  logic                 lsb_q, lsb_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;

  logic                 found;
  logic [IW-1:0]        pick;

  // First requesting index at or after ptr_q, wrapping NREQ-1 -> 0.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    rdata_d = rdata_q;
    terr_d  = terr_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    d_d     = d_q;
    s_d     = s_q;
    msb_d   = msb_q;
    lsb_d   = lsb_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          addr_d  = bus.req_addr[pick*ADDRWIDTH +: ADDRWIDTH];
          d_d     = bus.req_d[pick*DATAWIDTH +: DATAWIDTH];
          s_d     = bus.req_s[pick*SW +: SW];
          msb_d   = bus.req_msbin[pick];
          lsb_d   = bus.req_lsbin[pick];
          wr_en_d = bus.req_wr[pick];
          rd_en_d = ~bus.req_wr[pick];
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = bus.req_wr[pick] ? WR_WAIT : RD_WAIT;
        end
      end
      WR_WAIT: begin
        // Counting up to WR_WAIT_CYC puts done WR_WAIT_CYC+1 cycles after wr_en.
        if (cnt_q == CW'(WR_WAIT_CYC)) begin
          terr_d  = 1'b0;
          done_d  = NREQ'(1) << gnt_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD_WAIT: begin
        if (bus.DataValid) begin
          rdata_d = bus.dataout;
          terr_d  = 1'b0;
          done_d  = NREQ'(1) << gnt_q;
          state_d = DONE;
        end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
          rdata_d = '0;
          terr_d  = 1'b1;
          done_d  = NREQ'(1) << gnt_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        ptr_d   = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, including the RR pointer.
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      terr_q  <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      d_q     <= '0;
      s_q     <= '0;
      msb_q   <= 1'b0;
      lsb_q   <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      d_q     <= d_d;
      s_q     <= s_d;
      msb_q   <= msb_d;
      lsb_q   <= lsb_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
    end
  end

  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.timeout_err = terr_q;
  assign bus.busy        = busy_q;
  assign bus.addr        = addr_q;
  assign bus.D           = d_q;
  assign bus.S           = s_q;
  assign bus.MSBIn       = msb_q;
  assign bus.LSBIn       = lsb_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.rd_en       = rd_en_q;
endmodule

// File: tb/tb_i2c_xact_arbiter.sv
// Directed bench for i2c_xact_arbiter: write settle, read data/timeout,
// round-robin contention, mid-transaction reset and DataValid-vs-timeout priority.
module tb_i2c_xact_arbiter;
  logic clk = 1'b0;
  logic reset;

  int n_checks  = 0;
  int n_pass    = 0;
  int n_overlap = 0;

  always #5 clk = ~clk;

  i2c_xact_arbiter_if #(.DATAWIDTH(8), .ADDRWIDTH(6), .NREQ(2)) bus ();

  i2c_xact_arbiter #(
    .DATAWIDTH(8), .ADDRWIDTH(6), .NREQ(2), .WR_WAIT_CYC(40), .RD_TIMEOUT(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always @(negedge clk) if (bus.wr_en && bus.rd_en) n_overlap++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Steps to the cycle where done rises; lat=-1 if the bound expires.
  task automatic wait_done(input int max_cyc, output int lat, output logic busy_ok,
                           output int pulses);
    lat = -1; busy_ok = 1'b1; pulses = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.wr_en || bus.rd_en) pulses++;
      if (bus.done != 2'b00) begin
        lat = k;
        break;
      end
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.done, bus.rdata, bus.timeout_err, bus.busy, bus.addr, bus.D, bus.S,
                bus.MSBIn, bus.LSBIn, bus.wr_en, bus.rd_en});
  endfunction

  initial begin
    int       lat;
    logic     busy_ok;
    int       pulses;
    logic [1:0] grants [4];
    int       ng;

    reset          = 1'b1;
    bus.req        = '0;
    bus.req_wr     = '0;
    bus.req_addr   = '0;
    bus.req_d      = '0;
    bus.req_s      = '0;
    bus.req_msbin  = '0;
    bus.req_lsbin  = '0;
    bus.dataout    = '0;
    bus.DataValid  = 1'b0;
    cyc(3);
    check("reset_outputs", all_outs(), 64'd0);
    reset = 1'b0;
    cyc(1);

    // Single write from requester 0
    bus.req_wr[0]     = 1'b1;
    bus.req_addr[5:0] = 6'h0D;
    bus.req_d[7:0]    = 8'hE5;
    bus.req_s[2:0]    = 3'd1;
    bus.req_msbin[0]  = 1'b1;
    bus.req_lsbin[0]  = 1'b0;
    bus.req[0]        = 1'b1;
    cyc(1);
    check("wr_pulse", {62'd0, bus.wr_en, bus.rd_en}, 64'b10);
    check("wr_pins", 64'({bus.addr, bus.D, bus.S, bus.MSBIn, bus.LSBIn}),
          64'({6'h0D, 8'hE5, 3'd1, 1'b1, 1'b0}));
    check("wr_busy_grant", 64'(bus.busy), 64'd1);
    bus.req_d[7:0] = 8'h11;
    wait_done(100, lat, busy_ok, pulses);
    check("wr_done_latency", 64'(lat), 64'd41);
    check("wr_done_onehot", 64'(bus.done), 64'b01);
    check("wr_busy_held", 64'(busy_ok), 64'd1);
    check("wr_single_pulse", 64'(pulses), 64'd0);
    check("wr_timeout_err", 64'(bus.timeout_err), 64'd0);
    check("wr_d_held", 64'(bus.D), 64'hE5);
    bus.req[0] = 1'b0;
    cyc(1);
    check("wr_after_done", 64'({bus.busy, bus.done}), 64'd0);

    // Read with data from requester 1, DataValid three cycles after rd_en
    bus.req_wr[1]      = 1'b0;
    bus.req_addr[11:6] = 6'h0D;
    bus.req[1]         = 1'b1;
    cyc(1);
    check("rd_pulse", {62'd0, bus.wr_en, bus.rd_en}, 64'b01);
    check("rd_addr", 64'(bus.addr), 64'h0D);
    cyc(3);
    check("rd_no_early_done", 64'(bus.done), 64'd0);
    bus.dataout   = 8'hCA;
    bus.DataValid = 1'b1;
    cyc(1);
    check("rd_done_onehot", 64'(bus.done), 64'b10);
    check("rd_rdata", 64'(bus.rdata), 64'hCA);
    check("rd_timeout_err", 64'(bus.timeout_err), 64'd0);
    bus.DataValid = 1'b0;
    bus.dataout   = 8'h00;
    bus.req[1]    = 1'b0;
    cyc(1);
    check("rd_idle_after", 64'({bus.busy, bus.done}), 64'd0);
    check("rd_rdata_hold", 64'(bus.rdata), 64'hCA);

    // Read timeout from requester 0
    bus.req_wr[0]     = 1'b0;
    bus.req_addr[5:0] = 6'h2A;
    bus.req[0]        = 1'b1;
    cyc(1);
    check("to_rd_pulse", {62'd0, bus.wr_en, bus.rd_en}, 64'b01);
    wait_done(100, lat, busy_ok, pulses);
    check("to_latency", 64'(lat), 64'd64);
    check("to_done_onehot", 64'(bus.done), 64'b01);
    check("to_flags", 64'({bus.timeout_err, bus.rdata}), 64'({1'b1, 8'h00}));
    bus.req[0] = 1'b0;
    cyc(1);

    // DataValid on the timeout cycle from requester 1: data wins
    bus.req[1] = 1'b1;
    cyc(1);
    check("sim_rd_pulse", {62'd0, bus.wr_en, bus.rd_en}, 64'b01);
    cyc(63);
    check("sim_no_early_done", 64'(bus.done), 64'd0);
    bus.dataout   = 8'h5A;
    bus.DataValid = 1'b1;
    cyc(1);
    check("sim_done_onehot", 64'(bus.done), 64'b10);
    check("sim_flags", 64'({bus.timeout_err, bus.rdata}), 64'({1'b0, 8'h5A}));
    bus.DataValid = 1'b0;
    bus.req[1]    = 1'b0;
    cyc(1);

    // Contention: both request reads continuously, DataValid always high
    bus.req_wr    = 2'b00;
    bus.dataout   = 8'h33;
    bus.DataValid = 1'b1;
    bus.req       = 2'b11;
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      @(negedge clk);
      if (bus.done != 2'b00) begin
        grants[ng] = bus.done;
        ng++;
      end
    end
    bus.req       = 2'b00;
    bus.DataValid = 1'b0;
    check("rr_count", 64'(ng), 64'd4);
    check("rr_grant0", 64'(grants[0]), 64'b01);
    check("rr_grant1", 64'(grants[1]), 64'b10);
    check("rr_grant2", 64'(grants[2]), 64'b01);
    check("rr_grant3", 64'(grants[3]), 64'b10);
    check("rr_rdata", 64'(bus.rdata), 64'h33);
    cyc(2);

    // Move ptr to 1, then abort a write from requester 1 with reset
    bus.req       = 2'b01;
    bus.DataValid = 1'b1;
    cyc(2);
    check("pre_rst_done", 64'(bus.done), 64'b01);
    bus.req       = 2'b00;
    bus.DataValid = 1'b0;
    cyc(1);
    bus.req_wr[1]      = 1'b1;
    bus.req_addr[11:6] = 6'h3F;
    bus.req_d[15:8]    = 8'hA5;
    bus.req            = 2'b10;
    cyc(1);
    check("rst_wr_pulse", 64'({bus.wr_en, bus.addr, bus.D}), 64'({1'b1, 6'h3F, 8'hA5}));
    cyc(10);
    reset = 1'b1;
    cyc(1);
    check("rst_mid_outputs", all_outs(), 64'd0);
    reset         = 1'b0;
    bus.req_wr    = 2'b00;
    bus.req       = 2'b11;
    cyc(1);
    check("rst_ptr_grant", 64'({bus.rd_en, bus.addr, bus.done}), 64'({1'b1, 6'h2A, 2'b00}));
    bus.DataValid = 1'b1;
    bus.dataout   = 8'h77;
    cyc(1);
    check("rst_post_done", 64'({bus.done, bus.rdata}), 64'({2'b01, 8'h77}));
    bus.req       = 2'b00;
    bus.DataValid = 1'b0;
    cyc(2);

    check("no_wr_rd_overlap", 64'(n_overlap), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
